// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data-memory arbiter: funct3 codes,
// arbiter state encoding, the request bundle and the access legality check.
package dmem_pkg;

  localparam int DMEM_AW = 13;

  localparam logic [2:0] F_B  = 3'd0;
  localparam logic [2:0] F_H  = 3'd1;
  localparam logic [2:0] F_W  = 3'd2;
  localparam logic [2:0] F_BU = 3'd4;
  localparam logic [2:0] F_HU = 3'd5;

  typedef enum logic {
    IDLE     = 1'b0,
    DMA_LOCK = 1'b1
  } arb_state_e;

  typedef struct packed {
    logic               we;
    logic [DMEM_AW-1:0] addr;
    logic [31:0]        wdata;
    logic [2:0]         funct;
  } dmem_req_t;

  // Unsigned loads are read-only forms; halfword/word need natural alignment.
  function automatic logic is_legal(input logic we, input logic [2:0] funct,
                                    input logic [1:0] addr_lo);
    logic ok;
    case (funct)
      F_B:     ok = 1'b1;
      F_BU:    ok = ~we;
      F_H:     ok = ~addr_lo[0];
      F_HU:    ok = ~we & ~addr_lo[0];
      F_W:     ok = (addr_lo == 2'b00);
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// Bundle of the two master ports and the memory port around the arbiter.
interface dmem_arbiter_if
  import dmem_pkg::*;
#(
  parameter int DMEM_ADDR = DMEM_AW
);
  logic                 i_lsu_req;
  logic                 i_lsu_we;
  logic [DMEM_ADDR-1:0] i_lsu_addr;
  logic [31:0]          i_lsu_wdata;
  logic [2:0]           i_lsu_funct;
  logic                 o_lsu_gnt;
  logic                 o_lsu_rvalid;
  logic [31:0]          o_lsu_rdata;
  logic                 o_lsu_err;

  logic                 i_dma_req;
  logic                 i_dma_we;
  logic [DMEM_ADDR-1:0] i_dma_addr;
  logic [31:0]          i_dma_wdata;
  logic [2:0]           i_dma_funct;
  logic                 i_dma_last;
  logic                 o_dma_gnt;
  logic                 o_dma_rvalid;
  logic [31:0]          o_dma_rdata;
  logic                 o_dma_err;

  logic                 o_mem_en;
  logic                 o_mem_we;
  logic [DMEM_ADDR-1:0] o_mem_addr;
  logic [31:0]          o_mem_wdata;
  logic [2:0]           o_mem_funct;
  logic [31:0]          i_mem_rdata;

  modport slave (
    input  i_lsu_req, i_lsu_we, i_lsu_addr, i_lsu_wdata, i_lsu_funct,
    output o_lsu_gnt, o_lsu_rvalid, o_lsu_rdata, o_lsu_err,
    input  i_dma_req, i_dma_we, i_dma_addr, i_dma_wdata, i_dma_funct, i_dma_last,
    output o_dma_gnt, o_dma_rvalid, o_dma_rdata, o_dma_err,
    output o_mem_en, o_mem_we, o_mem_addr, o_mem_wdata, o_mem_funct,
    input  i_mem_rdata
  );

  modport master (
    output i_lsu_req, i_lsu_we, i_lsu_addr, i_lsu_wdata, i_lsu_funct,
    input  o_lsu_gnt, o_lsu_rvalid, o_lsu_rdata, o_lsu_err,
    output i_dma_req, i_dma_we, i_dma_addr, i_dma_wdata, i_dma_funct, i_dma_last,
    input  o_dma_gnt, o_dma_rvalid, o_dma_rdata, o_dma_err,
    input  o_mem_en, o_mem_we, o_mem_addr, o_mem_wdata, o_mem_funct,
    output i_mem_rdata
  );

endinterface

// File: rtl/dmem_resp_reg.sv
// One-cycle response register for a single master: rvalid follows its grant,
// load data is captured only for legal loads, err flags illegal accesses.
module dmem_resp_reg (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_fire,
  input  logic        i_legal,
  input  logic        i_load,
  input  logic [31:0] i_mem_rdata,
  output logic        o_rvalid,
  output logic        o_err,
  output logic [31:0] o_rdata
);
  logic        rvalid_d, rvalid_q;
  logic        err_d, err_q;
  logic [31:0] rdata_d, rdata_q;

  // Next response contents.
  always_comb begin
    rvalid_d = i_fire;
    err_d    = i_fire & ~i_legal;
    if (i_fire && i_legal && i_load) begin
      rdata_d = i_mem_rdata;
    end else begin
      rdata_d = 32'h0000_0000;
    end
  end

  // Response state; reset drops any in-flight response.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      rvalid_q <= 1'b0;
      err_q    <= 1'b0;
      rdata_q  <= 32'h0000_0000;
    end else begin
      rvalid_q <= rvalid_d;
      err_q    <= err_d;
      rdata_q  <= rdata_d;
    end
  end

  assign o_rvalid = rvalid_q;
  assign o_err    = err_q;
  assign o_rdata  = rdata_q;

endmodule

// File: rtl/dmem_arbiter.sv
// Two-master arbiter for the data memory port: LSU priority, DMA burst
// locking and a starvation counter that forces a waiting DMA through.
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int DMEM_ADDR  = DMEM_AW,
  parameter int STARVE_MAX = 8
) (
  input  logic           i_clk,
  input  logic           i_rst,
  dmem_arbiter_if.slave  bus
);
  localparam logic [7:0] STARVE_LIM = 8'(STARVE_MAX);

  arb_state_e state_q, state_d;
  logic [7:0] starve_q, starve_d;
  logic       lsu_req_s, dma_req_s, lsu_gnt_s, dma_gnt_s, legal_s;
  dmem_req_t  lsu_s, dma_s, win_s;

  // No grant may be issued while reset is held.
  assign lsu_req_s = bus.i_lsu_req & ~i_rst;
  assign dma_req_s = bus.i_dma_req & ~i_rst;
  assign lsu_s = '{we: bus.i_lsu_we, addr: bus.i_lsu_addr,
                   wdata: bus.i_lsu_wdata, funct: bus.i_lsu_funct};
  assign dma_s = '{we: bus.i_dma_we, addr: bus.i_dma_addr,
                   wdata: bus.i_dma_wdata, funct: bus.i_dma_funct};

  // Grant selection.
  always_comb begin
    lsu_gnt_s = 1'b0;
    dma_gnt_s = 1'b0;
    if (state_q == DMA_LOCK) begin
      dma_gnt_s = dma_req_s;
    end else if (dma_req_s && (!lsu_req_s || starve_q == STARVE_LIM)) begin
      dma_gnt_s = 1'b1;
    end else begin
      lsu_gnt_s = lsu_req_s;
    end
  end

  // Burst lock and starvation bookkeeping; illegal beats still advance the burst.
  always_comb begin
    state_d  = state_q;
    starve_d = starve_q;
    if (dma_gnt_s) begin
      state_d = bus.i_dma_last ? IDLE : DMA_LOCK;
    end else begin
      state_d = state_q;
    end
    if (!dma_req_s || dma_gnt_s) begin
      starve_d = 8'd0;
    end else if (starve_q != STARVE_LIM) begin
      starve_d = starve_q + 8'd1;
    end else begin
      starve_d = starve_q;
    end
  end

  // Memory port mux; all-zero when nobody is granted.
  always_comb begin
    if (lsu_gnt_s) begin
      win_s = lsu_s;
    end else if (dma_gnt_s) begin
      win_s = dma_s;
    end else begin
      win_s = '0;
    end
    legal_s = is_legal(win_s.we, win_s.funct, win_s.addr[1:0]);
  end

  assign bus.o_lsu_gnt   = lsu_gnt_s;
  assign bus.o_dma_gnt   = dma_gnt_s;
  assign bus.o_mem_en    = (lsu_gnt_s | dma_gnt_s) & legal_s;
  assign bus.o_mem_we    = win_s.we;
  assign bus.o_mem_addr  = win_s.addr;
  assign bus.o_mem_wdata = win_s.wdata;
  assign bus.o_mem_funct = win_s.funct;

  // Arbiter state.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q  <= IDLE;
      starve_q <= 8'd0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
    end
  end

  dmem_resp_reg u_lsu_resp (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_fire      (lsu_gnt_s),
    .i_legal     (legal_s),
    .i_load      (~win_s.we),
    .i_mem_rdata (bus.i_mem_rdata),
    .o_rvalid    (bus.o_lsu_rvalid),
    .o_err       (bus.o_lsu_err),
    .o_rdata     (bus.o_lsu_rdata)
  );

  dmem_resp_reg u_dma_resp (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_fire      (dma_gnt_s),
    .i_legal     (legal_s),
    .i_load      (~win_s.we),
    .i_mem_rdata (bus.i_mem_rdata),
    .o_rvalid    (bus.o_dma_rvalid),
    .o_err       (bus.o_dma_err),
    .o_rdata     (bus.o_dma_rdata)
  );

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a byte-addressed memory model that
// performs the funct-based read extension and byte-lane stores.
module tb_dmem_arbiter;
  import dmem_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   vectors = 0;
  int   miscompares = 0;

  dmem_arbiter_if #(.DMEM_ADDR(13)) bus ();

  dmem_arbiter #(.DMEM_ADDR(13), .STARVE_MAX(8)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  logic [7:0]  mem [0:8191] = '{default: 8'h00};
  logic [12:0] a0, a1, a2, a3;
  logic [31:0] mem_rd;

  assign a0 = bus.o_mem_addr;
  assign a1 = a0 + 13'd1;
  assign a2 = a0 + 13'd2;
  assign a3 = a0 + 13'd3;

  always_comb begin
    mem_rd = 32'h0000_0000;
    if (bus.o_mem_en) begin
      case (bus.o_mem_funct)
        3'd0:    mem_rd = {{24{mem[a0][7]}}, mem[a0]};
        3'd4:    mem_rd = {24'h000000, mem[a0]};
        3'd1:    mem_rd = {{16{mem[a1][7]}}, mem[a1], mem[a0]};
        3'd5:    mem_rd = {16'h0000, mem[a1], mem[a0]};
        3'd2:    mem_rd = {mem[a3], mem[a2], mem[a1], mem[a0]};
        default: mem_rd = 32'h0000_0000;
      endcase
    end
  end
  assign bus.i_mem_rdata = mem_rd;

  always @(posedge clk) begin
    if (bus.o_mem_en && bus.o_mem_we) begin
      case (bus.o_mem_funct)
        3'd0: mem[a0] <= bus.o_mem_wdata[7:0];
        3'd1: begin
          mem[a0] <= bus.o_mem_wdata[7:0];
          mem[a1] <= bus.o_mem_wdata[15:8];
        end
        3'd2: begin
          mem[a0] <= bus.o_mem_wdata[7:0];
          mem[a1] <= bus.o_mem_wdata[15:8];
          mem[a2] <= bus.o_mem_wdata[23:16];
          mem[a3] <= bus.o_mem_wdata[31:24];
        end
        default: ;
      endcase
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic lsu_drive(input logic req, input logic we, input logic [12:0] addr,
                           input logic [31:0] wdata, input logic [2:0] funct);
    bus.i_lsu_req   = req;
    bus.i_lsu_we    = we;
    bus.i_lsu_addr  = addr;
    bus.i_lsu_wdata = wdata;
    bus.i_lsu_funct = funct;
  endtask

  task automatic dma_drive(input logic req, input logic we, input logic [12:0] addr,
                           input logic [31:0] wdata, input logic [2:0] funct,
                           input logic last);
    bus.i_dma_req   = req;
    bus.i_dma_we    = we;
    bus.i_dma_addr  = addr;
    bus.i_dma_wdata = wdata;
    bus.i_dma_funct = funct;
    bus.i_dma_last  = last;
  endtask

  initial begin
    lsu_drive(1'b1, 1'b0, 13'h010, 32'h0, F_W);
    dma_drive(1'b0, 1'b0, 13'h000, 32'h0, F_W, 1'b1);
    #12;
    chk("rst_lsu_gnt",    {31'd0, bus.o_lsu_gnt},    32'd0);
    chk("rst_mem_en",     {31'd0, bus.o_mem_en},     32'd0);
    chk("rst_lsu_rvalid", {31'd0, bus.o_lsu_rvalid}, 32'd0);
    chk("rst_dma_rvalid", {31'd0, bus.o_dma_rvalid}, 32'd0);
    chk("rst_lsu_rdata",  bus.o_lsu_rdata,           32'd0);
    tick();
    rst = 1'b0;
    lsu_drive(1'b0, 1'b0, 13'h000, 32'h0, F_W);
    tick();

    // sw then lw at 0x010
    lsu_drive(1'b1, 1'b1, 13'h010, 32'hDEAD_BEEF, F_W);
    #1;
    chk("sw_gnt",     {31'd0, bus.o_lsu_gnt}, 32'd1);
    chk("sw_mem_en",  {31'd0, bus.o_mem_en},  32'd1);
    chk("sw_mem_we",  {31'd0, bus.o_mem_we},  32'd1);
    chk("sw_dma_gnt", {31'd0, bus.o_dma_gnt}, 32'd0);
    tick();
    chk("sw_rvalid", {31'd0, bus.o_lsu_rvalid}, 32'd1);
    chk("sw_err",    {31'd0, bus.o_lsu_err},    32'd0);
    chk("sw_rdata",  bus.o_lsu_rdata,           32'd0);
    lsu_drive(1'b1, 1'b0, 13'h010, 32'h0, F_W);
    #1;
    chk("lw_gnt", {31'd0, bus.o_lsu_gnt}, 32'd1);
    tick();
    chk("lw_rvalid", {31'd0, bus.o_lsu_rvalid}, 32'd1);
    chk("lw_rdata",  bus.o_lsu_rdata,           32'hDEAD_BEEF);
    chk("lw_err",    {31'd0, bus.o_lsu_err},    32'd0);

    // misaligned lh, misaligned sw, store with unsigned funct
    lsu_drive(1'b1, 1'b0, 13'h011, 32'h0, F_H);
    #1;
    chk("lh_mis_gnt",    {31'd0, bus.o_lsu_gnt}, 32'd1);
    chk("lh_mis_mem_en", {31'd0, bus.o_mem_en},  32'd0);
    tick();
    chk("lh_mis_rvalid", {31'd0, bus.o_lsu_rvalid}, 32'd1);
    chk("lh_mis_err",    {31'd0, bus.o_lsu_err},    32'd1);
    chk("lh_mis_rdata",  bus.o_lsu_rdata,           32'd0);
    lsu_drive(1'b1, 1'b1, 13'h012, 32'h1111_1111, F_W);
    #1;
    chk("sw_mis_mem_en", {31'd0, bus.o_mem_en}, 32'd0);
    tick();
    chk("sw_mis_err", {31'd0, bus.o_lsu_err}, 32'd1);
    lsu_drive(1'b1, 1'b1, 13'h010, 32'h2222_2222, F_BU);
    #1;
    chk("sbu_mem_en", {31'd0, bus.o_mem_en}, 32'd0);
    tick();
    chk("sbu_err", {31'd0, bus.o_lsu_err}, 32'd1);
    lsu_drive(1'b1, 1'b0, 13'h010, 32'h0, F_W);
    tick();
    chk("unchanged_rdata", bus.o_lsu_rdata, 32'hDEAD_BEEF);
    lsu_drive(1'b1, 1'b0, 13'h012, 32'h0, F_HU);
    tick();
    chk("lhu_rdata", bus.o_lsu_rdata, 32'h0000_DEAD);
    lsu_drive(1'b1, 1'b0, 13'h012, 32'h0, F_H);
    tick();
    chk("lh_rdata", bus.o_lsu_rdata, 32'hFFFF_DEAD);

    // DMA byte store and signed/unsigned byte loads
    lsu_drive(1'b0, 1'b0, 13'h000, 32'h0, F_W);
    dma_drive(1'b1, 1'b1, 13'h003, 32'h0000_0080, F_B, 1'b1);
    #1;
    chk("sb_dma_gnt", {31'd0, bus.o_dma_gnt}, 32'd1);
    chk("sb_lsu_gnt", {31'd0, bus.o_lsu_gnt}, 32'd0);
    chk("sb_mem_en",  {31'd0, bus.o_mem_en},  32'd1);
    tick();
    chk("sb_dma_rvalid", {31'd0, bus.o_dma_rvalid}, 32'd1);
    chk("sb_lsu_rvalid", {31'd0, bus.o_lsu_rvalid}, 32'd0);
    dma_drive(1'b1, 1'b0, 13'h003, 32'h0, F_B, 1'b1);
    tick();
    chk("lb_rdata", bus.o_dma_rdata, 32'hFFFF_FF80);
    dma_drive(1'b1, 1'b0, 13'h003, 32'h0, F_BU, 1'b1);
    tick();
    chk("lbu_rdata", bus.o_dma_rdata, 32'h0000_0080);
    chk("lbu_err",   {31'd0, bus.o_dma_err}, 32'd0);

    // both request continuously: 8 LSU wins, forced DMA win, then LSU again
    lsu_drive(1'b1, 1'b0, 13'h010, 32'h0, F_W);
    dma_drive(1'b1, 1'b0, 13'h010, 32'h0, F_W, 1'b1);
    for (int k = 1; k <= 10; k++) begin
      #1;
      chk($sformatf("starve_lsu_gnt_%0d", k), {31'd0, bus.o_lsu_gnt}, (k != 9) ? 32'd1 : 32'd0);
      chk($sformatf("starve_dma_gnt_%0d", k), {31'd0, bus.o_dma_gnt}, (k == 9) ? 32'd1 : 32'd0);
      tick();
      chk($sformatf("starve_lsu_rv_%0d", k), {31'd0, bus.o_lsu_rvalid}, (k != 9) ? 32'd1 : 32'd0);
      chk($sformatf("starve_dma_rv_%0d", k), {31'd0, bus.o_dma_rvalid}, (k == 9) ? 32'd1 : 32'd0);
    end

    // 4-beat DMA burst with a wait state and an illegal beat
    lsu_drive(1'b0, 1'b0, 13'h000, 32'h0, F_W);
    dma_drive(1'b1, 1'b1, 13'h100, 32'hA0A0_0001, F_W, 1'b0);
    #1;
    chk("b1_dma_gnt", {31'd0, bus.o_dma_gnt}, 32'd1);
    tick();
    lsu_drive(1'b1, 1'b0, 13'h104, 32'h0, F_W);
    dma_drive(1'b1, 1'b1, 13'h104, 32'hB0B0_0002, F_W, 1'b0);
    #1;
    chk("b2_dma_gnt", {31'd0, bus.o_dma_gnt}, 32'd1);
    chk("b2_lsu_gnt", {31'd0, bus.o_lsu_gnt}, 32'd0);
    tick();
    dma_drive(1'b0, 1'b0, 13'h000, 32'h0, F_W, 1'b0);
    #1;
    chk("ws_lsu_gnt", {31'd0, bus.o_lsu_gnt}, 32'd0);
    chk("ws_dma_gnt", {31'd0, bus.o_dma_gnt}, 32'd0);
    chk("ws_mem_en",  {31'd0, bus.o_mem_en},  32'd0);
    tick();
    dma_drive(1'b1, 1'b1, 13'h108, 32'hC0C0_0003, 3'd3, 1'b0);
    #1;
    chk("b3_dma_gnt", {31'd0, bus.o_dma_gnt}, 32'd1);
    chk("b3_lsu_gnt", {31'd0, bus.o_lsu_gnt}, 32'd0);
    chk("b3_mem_en",  {31'd0, bus.o_mem_en},  32'd0);
    tick();
    chk("b3_dma_rvalid", {31'd0, bus.o_dma_rvalid}, 32'd1);
    chk("b3_dma_err",    {31'd0, bus.o_dma_err},    32'd1);
    dma_drive(1'b1, 1'b1, 13'h10C, 32'hD0D0_0004, F_W, 1'b1);
    #1;
    chk("b4_dma_gnt", {31'd0, bus.o_dma_gnt}, 32'd1);
    chk("b4_lsu_gnt", {31'd0, bus.o_lsu_gnt}, 32'd0);
    tick();
    chk("b4_dma_err", {31'd0, bus.o_dma_err}, 32'd0);
    dma_drive(1'b0, 1'b0, 13'h000, 32'h0, F_W, 1'b1);
    #1;
    chk("post_lsu_gnt", {31'd0, bus.o_lsu_gnt}, 32'd1);
    tick();
    chk("post_rdata", bus.o_lsu_rdata, 32'hB0B0_0002);
    lsu_drive(1'b1, 1'b0, 13'h108, 32'h0, F_W);
    tick();
    chk("b3_nowrite_rdata", bus.o_lsu_rdata, 32'd0);

    // reset while locked with a response pending
    lsu_drive(1'b0, 1'b0, 13'h000, 32'h0, F_W);
    dma_drive(1'b1, 1'b0, 13'h010, 32'h0, F_W, 1'b0);
    #1;
    chk("rl_dma_gnt", {31'd0, bus.o_dma_gnt}, 32'd1);
    tick();
    chk("rl_dma_rvalid", {31'd0, bus.o_dma_rvalid}, 32'd1);
    rst = 1'b1;
    #1;
    chk("rl_rvalid_cleared", {31'd0, bus.o_dma_rvalid}, 32'd0);
    dma_drive(1'b0, 1'b0, 13'h000, 32'h0, F_W, 1'b1);
    lsu_drive(1'b1, 1'b0, 13'h010, 32'h0, F_W);
    #1;
    chk("rl_gnt_in_rst", {31'd0, bus.o_lsu_gnt}, 32'd0);
    tick();
    rst = 1'b0;
    #1;
    chk("rl_lsu_gnt_after", {31'd0, bus.o_lsu_gnt}, 32'd1);
    tick();
    chk("rl_lsu_rdata", bus.o_lsu_rdata, 32'hDEAD_BEEF);
    lsu_drive(1'b0, 1'b0, 13'h000, 32'h0, F_W);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
Two-port arbiter and access sequencer in front of the byte-addressed data memory. It shares the single memory port between the pipeline LSU and a DMA/debug master. It enforces alignment and funct legality, and returns registered read data with a one-cycle response. It also provides DMA burst locking and an anti-starvation counter so the DMA master always makes progress under continuous LSU traffic.

Parameters:
DMEM_ADDR, 13, byte-address width of the data memory port.
STARVE_MAX, 8, consecutive cycles a pending DMA request may lose before it is forced to win; legal range 1..255.

Ports:
i_clk  in  1  clock; all state updates on rising edge.
i_rst  in  1  asynchronous, active-high reset.
i_lsu_req  in  1  LSU access request; held until granted.
i_lsu_we  in  1  1 = store, 0 = load.
i_lsu_addr  in  DMEM_ADDR  LSU byte address.
i_lsu_wdata  in  32  LSU store data, LSB-aligned.
i_lsu_funct  in  3  RV funct3: 0 = B, 1 = H, 2 = W, 4 = BU, 5 = HU.
o_lsu_gnt  out  1  request accepted this cycle (combinational).
o_lsu_rvalid  out  1  response valid; one cycle after gnt, for loads and stores.
o_lsu_rdata  out  32  registered load data; 0 for stores and errors.
o_lsu_err  out  1  qualified by rvalid: misaligned or illegal access.
i_dma_req, i_dma_we, i_dma_addr, i_dma_wdata, i_dma_funct  in  1/1/DMEM_ADDR/32/3  DMA request fields; same meaning as the LSU fields.
i_dma_last  in  1  final beat of a DMA burst; 1 for single accesses.
o_dma_gnt, o_dma_rvalid, o_dma_rdata, o_dma_err  out  1/1/32/1  DMA response fields; same meaning as the LSU fields.
o_mem_en  out  1  memory select.
o_mem_we  out  1  memory write enable.
o_mem_addr  out  DMEM_ADDR  memory address.
o_mem_wdata  out  32  memory write data.
o_mem_funct  out  3  memory funct code.
i_mem_rdata  in  32  combinational memory read data; valid while o_mem_en = 1.

Behaviour:
- Reset (async, i_rst = 1):
  - state = IDLE, starve_cnt = 0.
  - all rvalid/err outputs 0; all rdata outputs 0.
  - In-flight responses are dropped; no grant or mem_en is asserted while i_rst = 1.
- FSM states: IDLE, DMA_LOCK.
  - IDLE: if both masters request, the LSU wins, unless starve_cnt == STARVE_MAX, in which case the DMA wins. A single requester always wins.
  - IDLE -> DMA_LOCK on a DMA grant with i_dma_last = 0.
  - DMA_LOCK: only the DMA may be granted; the LSU stalls (gnt = 0).
  - DMA_LOCK -> IDLE on a DMA grant with i_dma_last = 1.
  - DMA_LOCK with no DMA request: remain locked (wait-state beat).
- Starvation counter:
  - Increments each cycle i_dma_req = 1 and o_dma_gnt = 0; saturates at STARVE_MAX.
  - Clears to 0 on any DMA grant or when i_dma_req = 0.
- Grant cycle:
  - o_mem_* are driven combinationally from the winner's fields.
  - o_mem_en = 1 only for a legal access.
  - Stores commit at the closing clock edge.
  - Load data i_mem_rdata is captured at that edge into the winner's rdata register.
- Response timing:
  - The winner's rvalid = 1 for exactly one cycle following the grant.
  - Fixed latency of 1; at most one outstanding access per master.
  - The non-winner's rvalid = 0.
- Legality. An access is illegal when any of these holds:
  - funct is 3, 6 or 7;
  - a store uses funct 4 or 5;
  - a halfword access has addr[0] = 1;
  - a word access has addr[1:0] != 0.
- Illegal access handling:
  - Still granted (consumed), o_mem_en = 0, no memory side effect.
  - The following cycle: rvalid = 1, err = 1, rdata = 0.
- Idle outputs: when no grant is issued, o_mem_en = 0 and the other o_mem_* outputs are 0 (no floating outputs).
- Address wrap: beyond DMEM_ADDR the address wraps naturally; no range check in this block.
- Burst error: a DMA beat that is illegal still advances the burst state per i_dma_last.

Decomposition:
- Shared package dmem_pkg:
  - funct3 localparams (F_B, F_H, F_W, F_BU, F_HU);
  - the arb_state_e enum {IDLE, DMA_LOCK};
  - a dmem_req_t struct (we, addr, wdata, funct);
  - an is_legal() function.
- One sub-module, dmem_resp_reg: per-master rvalid/rdata/err register, instantiated twice.

Test Plan:
- LSU lw from 0x010 after a sw of 0xDEADBEEF to 0x010 -> two grants, second rvalid carries rdata 0xDEADBEEF, err = 0.
- LSU lh from 0x011 -> gnt = 1, o_mem_en = 0, next cycle rvalid = 1, err = 1, rdata = 0; memory unchanged.
- Both masters request continuously with STARVE_MAX = 8 -> LSU wins 8 cycles, DMA granted on cycle 9, counter returns to 0.
- DMA 4-beat burst (last = 0,0,0,1) with LSU requesting throughout -> LSU gnt = 0 for all 4 beats, LSU granted the cycle after the last beat.
- i_rst pulsed while in DMA_LOCK with a pending rvalid -> all rvalid = 0 immediately, state IDLE, next LSU request granted.
- DMA lb from 0x003 holding 0x80 -> rdata 0xFFFFFF80; lbu -> rdata 0x00000080.
